// File: rtl/scanline_scanout.sv
// Raster scan-out from ping-pong line buffers: counters, 2-stage
// pipeline to pixel/de/hsync/vsync, alternating even/odd VRAM reads.
module scanline_scanout #(
  parameter int   H_PIXELS      = 800,
  parameter int   H_FRONT_PORCH = 48,
  parameter int   H_SYNC        = 32,
  parameter int   H_BACK_PORCH  = 80,
  parameter int   V_PIXELS      = 600,
  parameter int   V_FRONT_PORCH = 3,
  parameter int   V_SYNC        = 4,
  parameter int   V_BACK_PORCH  = 11,
  parameter logic HSYNC_ACTIVE  = 1'b1,
  parameter logic VSYNC_ACTIVE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] vram_even_addr,
  input  logic [7:0] vram_even_q,
  output logic [9:0] vram_odd_addr,
  input  logic [7:0] vram_odd_q,
  output logic [7:0] pixel,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_PIXELS + H_FRONT_PORCH
                         + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_PIXELS + V_FRONT_PORCH
                         + V_SYNC + V_BACK_PORCH;
  localparam int HC = $clog2(H_TOTAL);
  localparam int HW = (HC > 10) ? HC : 10;
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_PIXELS);
  localparam logic [HW-1:0] HS_BEG = HW'(H_PIXELS + H_FRONT_PORCH);
  localparam logic [HW-1:0] HS_END = HW'(H_PIXELS + H_FRONT_PORCH
                                        + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_PIXELS);
  localparam logic [VW-1:0] VS_BEG = VW'(V_PIXELS + V_FRONT_PORCH);
  localparam logic [VW-1:0] VS_END = VW'(V_PIXELS + V_FRONT_PORCH
                                        + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          read_sel;

  logic h_wrap, v_wrap, h_act;
  logic de0, hs0, vs0, fs0;
  logic de1, hs1, vs1, fs1, sel1;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  // Renderer writes even at v=0, so scan-out starts on odd
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h        <= '0;
      v        <= '0;
      read_sel <= 1'b0;
    end else if (h_wrap) begin
      h <= '0;
      if (v_wrap) begin
        v        <= '0;
        read_sel <= 1'b0;
      end else begin
        v        <= v + 1'b1;
        read_sel <= ~read_sel;
      end
    end else begin
      h <= h + 1'b1;
    end
  end

  assign h_act = (h < H_ACT);
  assign de0   = h_act && (v < V_ACT);
  assign hs0   = (h >= HS_BEG) && (h < HS_END);
  assign vs0   = (v >= VS_BEG) && (v < VS_END);
  assign fs0   = (h == '0) && (v == '0);

  assign vram_even_addr = h_act ? h[9:0] : 10'd0;
  assign vram_odd_addr  = h_act ? h[9:0] : 10'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      fs1         <= 1'b0;
      sel1        <= 1'b0;
      pixel       <= 8'h00;
      de          <= 1'b0;
      hsync       <= ~HSYNC_ACTIVE;
      vsync       <= ~VSYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      de1         <= de0;
      hs1         <= hs0;
      vs1         <= vs0;
      fs1         <= fs0;
      sel1        <= read_sel;
      pixel       <= de1 ? (sel1 ? vram_even_q : vram_odd_q)
                         : 8'h00;
      de          <= de1;
      hsync       <= hs1 ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync       <= vs1 ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      frame_start <= fs1;
    end
  end

endmodule

// File: tb/tb_scanline_scanout.sv
// Directed checks of scanline_scanout on a shrunken raster:
// 28 clk/line (16 active, hsync 20..22), 13 lines (6 active, vsync 8..9).
module tb_scanline_scanout;

  localparam int HT = 28;
  localparam int VT = 13;
  localparam int FT = HT * VT;

  logic       clk;
  logic       rst_n;
  logic [9:0] vram_even_addr;
  logic [7:0] vram_even_q;
  logic [9:0] vram_odd_addr;
  logic [7:0] vram_odd_q;
  logic [7:0] pixel;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  int vectors = 0;
  int errors  = 0;
  int cur_t   = -1;
  logic mode_const = 1'b0;

  scanline_scanout #(
    .H_PIXELS(16), .H_FRONT_PORCH(4), .H_SYNC(3), .H_BACK_PORCH(5),
    .V_PIXELS(6),  .V_FRONT_PORCH(2), .V_SYNC(2), .V_BACK_PORCH(3),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vram_even_addr(vram_even_addr),
    .vram_even_q(vram_even_q),
    .vram_odd_addr(vram_odd_addr),
    .vram_odd_q(vram_odd_q),
    .pixel(pixel),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line buffers with a registered read port
  always @(posedge clk) begin
    vram_even_q <= mode_const ? 8'hAA : vram_even_addr[7:0];
    vram_odd_q  <= mode_const ? 8'h55 : vram_odd_addr[7:0];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h",
             tag, cur_t, obs, exp);
    end
  endtask

  task automatic chk_idle(input logic [9:0] addr);
    chk("idle_pixel", 16'(pixel), 16'h00);
    chk("idle_de", 16'(de), 16'd0);
    chk("idle_fs", 16'(frame_start), 16'd0);
    chk("idle_hsync", 16'(hsync), 16'd0);
    chk("idle_vsync", 16'(vsync), 16'd1);
    chk("idle_even_addr", 16'(vram_even_addr), 16'(addr));
    chk("idle_odd_addr", 16'(vram_odd_addr), 16'(addr));
  endtask

  // Outputs show raster time t; the counter is already at t+2
  task automatic check_t(input int t);
    int tf, h, v, hn;
    logic [7:0] px;
    logic       a;
    cur_t = t;
    tf = t % FT;
    h  = tf % HT;
    v  = tf / HT;
    hn = ((t + 2) % FT) % HT;
    a  = (h < 16) && (v < 6);
    if (!a)
      px = 8'h00;
    else if (mode_const)
      px = (v % 2 == 0) ? 8'h55 : 8'hAA;
    else
      px = 8'(h);
    chk("pixel", 16'(pixel), 16'(px));
    chk("de", 16'(de), 16'(a));
    chk("hsync", 16'(hsync), 16'((h >= 20) && (h < 23)));
    chk("vsync", 16'(vsync), 16'(!((v >= 8) && (v < 10))));
    chk("frame_start", 16'(frame_start), 16'((h == 0) && (v == 0)));
    chk("even_addr", 16'(vram_even_addr), 16'((hn < 16) ? hn : 0));
    chk("odd_addr", 16'(vram_odd_addr), 16'((hn < 16) ? hn : 0));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk_idle(10'd0);

    rst_n = 1'b1;
    tick();
    chk_idle(10'd1);
    tick();
    chk("rel_de", 16'(de), 16'd1);
    chk("rel_fs", 16'(frame_start), 16'd1);

    for (int t = 0; t <= 2 * FT + 3 * HT + 8; t++) begin
      check_t(t);
      if (t == 340) mode_const = 1'b1;
      if (t < 2 * FT + 3 * HT + 8) tick();
    end

    rst_n = 1'b0;
    tick();
    cur_t = -1;
    chk_idle(10'd0);
    rst_n = 1'b1;
    tick();
    chk_idle(10'd1);
    tick();

    for (int t = 0; t <= FT + 40; t++) begin
      check_t(t);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
